id_ex_alu_issue: RTL and testbench
==================================

Name: id_ex_alu_issue

Overview:
- Decode/issue stage and ID/EX pipeline register for the MIPS32 pipeline.
- Accepts a fetched instruction plus register-file read data, and decodes it into the execute-stage ALU control word (ALUFun, Sign) and the ALU A/B operands.
- Registers all outputs toward EX behind a valid/ready handshake with stall and flush.
- Acts as the producer end of the ALU control interface.

Parameters:
- RA_IDX, 5'd31, link register index for jal.
- NOP_FUN, 6'b011010, ALUFun used for bubbles (logic pass-A).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction word valid from IF/ID.
- in_ready  output  1  stage can accept an instruction this cycle.
- instr  input  32  instruction word.
- pc_plus4  input  32  PC+4 of instr.
- rs_data  input  32  register-file data for instr[25:21].
- rt_data  input  32  register-file data for instr[20:16].
- flush  input  1  kill the held entry and the incoming entry (branch/jump redirect).
- out_valid  output  1  EX entry valid.
- out_ready  input  1  EX consumes the entry.
- alu_a  output  32  ALU operand A (shift amount for shifts).
- alu_b  output  32  ALU operand B.
- alu_fun  output  6  ALUFun control.
- alu_sign  output  1  1 = signed compare/overflow semantics.
- wr_addr  output  5  destination register.
- reg_write, mem_read, mem_write, is_branch, is_jump_reg  output  1 each  control flags.
- store_data  output  32  rt_data for sw.
- br_target  output  32  pc_plus4 + (sext(imm)<<2).
- illegal  output  1  unrecognised encoding.

Behaviour:
- Reset: out_valid=0, all data outputs 0, alu_fun=NOP_FUN, all flags 0. Reset overrides flush and the handshake.
- Handshake: in_ready = ~out_valid | out_ready (combinational). A load occurs when in_valid & in_ready & ~flush. Latency is 1 cycle from accept to out_valid.
- Hold: when out_valid & ~out_ready, all outputs stay stable.
- Drain: out_ready without a new load sets out_valid=0.
- flush=1: next cycle out_valid=0 and all flags are cleared, regardless of out_ready or in_valid.
- ALUFun encoding: [5:4] 00 add/sub, 01 logic, 10 shift, 11 compare.
  - add 000000, sub 000001.
  - and 011000, or 011110, xor 010110, nor 010001, passA 011010.
  - sll 100000, srl 100001, sra 100011.
  - eq 110011, ne 110001, lt 110101.
  - ltz 111011, lez 111101, gtz 111111.
- Decode, R-type (op=0, wr_addr=rd, A=rs, B=rt):
  - funct 20/21 add.
  - funct 22/23 sub.
  - funct 24/25/26/27 and/or/xor/nor.
  - funct 2A/2B lt.
  - funct 00/02/03 sll/srl/sra with A=zext(shamt).
  - funct 04/06/07 variable shifts with A=rs.
  - funct 08 jr: is_jump_reg=1, reg_write=0.
  - funct 09 jalr: A=pc_plus4, passA, is_jump_reg=1.
  - alu_sign=1 for 20, 22, 2A; otherwise 0.
- Decode, I-type (wr_addr=rt, A=rs):
  - addi 08 / addiu 09: B=sext(imm), add.
  - slti 0A / sltiu 0B: B=sext(imm), lt.
  - andi/ori/xori (0C/0D/0E): B=zext(imm).
  - lui 0F: A=16, B=zext(imm), sll.
  - lw 23: add, mem_read=1.
  - sw 2B: add, mem_write=1, reg_write=0.
  - Signed ops: 08, 0A, 23, 2B.
- Decode, branches (reg_write=0, is_branch=1, alu_sign=1):
  - beq 04 eq (B=rt), bne 05 ne (B=rt).
  - blez 06 lez, bgtz 07 gtz.
  - op 01 with rt=0: bltz, ltz.
- Decode, jumps:
  - j 02: is_jump_reg=0, no write.
  - jal 03: A=pc_plus4, passA, wr_addr=RA_IDX, reg_write=1.
- Writes with wr_addr=0 force reg_write=0.
- Unlisted op/funct: illegal=1 with all write/mem/branch flags 0. out_valid still asserts.
- Arithmetic: br_target uses 32-bit wrap-around, computed for every instruction.

Test Plan:
- reset held 2 cycles, then released -> out_valid=0, alu_fun=011010, in_ready=1.
- add $3,$1,$2 (instr 0x00221820), rs=5, rt=7 -> next cycle out_valid=1, alu_fun=000000, alu_sign=1, a=5, b=7, wr_addr=3, reg_write=1.
- sra $4,$5,3 (0x000520C3), rt=0x80000000 -> alu_fun=100011, a=3, b=0x80000000, wr_addr=4.
- Hold case: entry valid, out_ready=0, new instruction presented -> in_ready=0, outputs unchanged for 3 cycles; out_ready=1 -> next entry loads the following cycle.
- beq with imm=0xFFFF, pc_plus4=0x100 -> alu_fun=110011, is_branch=1, br_target=0xFC, reg_write=0.
- flush asserted while an entry is held and in_valid=1 -> next cycle out_valid=0.
- Opcode 0x3F -> illegal=1, reg_write=0.
- reset asserted mid-hold -> out_valid=0 the following cycle.

Source files
------------

// File: rtl/id_ex_alu_issue.sv
// rtl/id_ex_alu_issue.sv - MIPS32 decode/issue stage and ID/EX pipeline register
//
// Decodes one instruction per accepted handshake into the EX-stage ALU control
// word and operands, and holds it in a valid/ready register toward EX.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   instruction handshake from IF/ID
//   instr, pc_plus4     instruction word and its PC+4
//   rs_data, rt_data    register-file read data for instr[25:21] / instr[20:16]
//   flush               kill held and incoming entry (redirect)
//   out_valid/out_ready EX entry handshake
//   alu_a, alu_b        ALU operands (alu_a carries the shift amount for shifts)
//   alu_fun, alu_sign   ALU control word
//   wr_addr, reg_write, mem_read, mem_write, is_branch, is_jump_reg
//                       destination and control flags
//   store_data          rt_data, used by sw
//   br_target           pc_plus4 + (sext(imm) << 2)
//   illegal             unrecognised encoding
module id_ex_alu_issue #(
   parameter logic [4:0] RA_IDX  = 5'd31,
   parameter logic [5:0] NOP_FUN = 6'b011010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [5:0]  alu_fun,
   output logic        alu_sign,
   output logic [4:0]  wr_addr,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        is_branch,
   output logic        is_jump_reg,
   output logic [31:0] store_data,
   output logic [31:0] br_target,
   output logic        illegal
);

   localparam logic [5:0] F_ADD = 6'b000000, F_SUB = 6'b000001;
   localparam logic [5:0] F_AND = 6'b011000, F_OR  = 6'b011110;
   localparam logic [5:0] F_XOR = 6'b010110, F_NOR = 6'b010001;
   localparam logic [5:0] F_SLL = 6'b100000, F_SRL = 6'b100001, F_SRA = 6'b100011;
   localparam logic [5:0] F_EQ  = 6'b110011, F_NE  = 6'b110001, F_LT  = 6'b110101;
   localparam logic [5:0] F_LTZ = 6'b111011, F_LEZ = 6'b111101, F_GTZ = 6'b111111;

   logic [5:0]  op, funct;
   logic [4:0]  rt_idx, rd_idx, shamt;
   logic [15:0] imm;
   logic [31:0] sext_imm, zext_imm;

   assign op       = instr[31:26];
   assign rt_idx   = instr[20:16];
   assign rd_idx   = instr[15:11];
   assign shamt    = instr[10:6];
   assign funct    = instr[5:0];
   assign imm      = instr[15:0];
   assign sext_imm = {{16{imm[15]}}, imm};
   assign zext_imm = {16'h0000, imm};

   logic [31:0] d_a, d_b, d_target;
   logic [5:0]  d_fun;
   logic [4:0]  d_wr;
   logic        d_sign, d_rw, d_mr, d_mw, d_br, d_jr, d_ill;

   assign d_target = pc_plus4 + {sext_imm[29:0], 2'b00};

   always_comb begin
      d_a    = rs_data;
      d_b    = rt_data;
      d_fun  = NOP_FUN;
      d_sign = 1'b0;
      d_wr   = (op == 6'h00) ? rd_idx : rt_idx;
      d_rw   = 1'b0;
      d_mr   = 1'b0;
      d_mw   = 1'b0;
      d_br   = 1'b0;
      d_jr   = 1'b0;
      d_ill  = 1'b0;
      case (op)
         6'h00: begin
            case (funct)
               6'h20, 6'h21: begin d_fun = F_ADD; d_rw = 1'b1; end
               6'h22, 6'h23: begin d_fun = F_SUB; d_rw = 1'b1; end
               6'h24:        begin d_fun = F_AND; d_rw = 1'b1; end
               6'h25:        begin d_fun = F_OR;  d_rw = 1'b1; end
               6'h26:        begin d_fun = F_XOR; d_rw = 1'b1; end
               6'h27:        begin d_fun = F_NOR; d_rw = 1'b1; end
               6'h2A, 6'h2B: begin d_fun = F_LT;  d_rw = 1'b1; end
               6'h00: begin d_fun = F_SLL; d_a = {27'h0, shamt}; d_rw = 1'b1; end
               6'h02: begin d_fun = F_SRL; d_a = {27'h0, shamt}; d_rw = 1'b1; end
               6'h03: begin d_fun = F_SRA; d_a = {27'h0, shamt}; d_rw = 1'b1; end
               6'h04:        begin d_fun = F_SLL; d_rw = 1'b1; end
               6'h06:        begin d_fun = F_SRL; d_rw = 1'b1; end
               6'h07:        begin d_fun = F_SRA; d_rw = 1'b1; end
               6'h08:        d_jr = 1'b1;
               // jalr: the link value passes through the ALU on operand A
               6'h09:        begin d_a = pc_plus4; d_jr = 1'b1; d_rw = 1'b1; end
               default:      d_ill = 1'b1;
            endcase
            d_sign = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h2A);
         end
         6'h08: begin d_fun = F_ADD; d_b = sext_imm; d_rw = 1'b1; d_sign = 1'b1; end
         6'h09: begin d_fun = F_ADD; d_b = sext_imm; d_rw = 1'b1; end
         6'h0A: begin d_fun = F_LT;  d_b = sext_imm; d_rw = 1'b1; d_sign = 1'b1; end
         6'h0B: begin d_fun = F_LT;  d_b = sext_imm; d_rw = 1'b1; end
         6'h0C: begin d_fun = F_AND; d_b = zext_imm; d_rw = 1'b1; end
         6'h0D: begin d_fun = F_OR;  d_b = zext_imm; d_rw = 1'b1; end
         6'h0E: begin d_fun = F_XOR; d_b = zext_imm; d_rw = 1'b1; end
         // lui is imm << 16 through the shifter
         6'h0F: begin d_fun = F_SLL; d_a = 32'd16; d_b = zext_imm; d_rw = 1'b1; end
         6'h23: begin d_fun = F_ADD; d_b = sext_imm; d_rw = 1'b1; d_mr = 1'b1; d_sign = 1'b1; end
         6'h2B: begin d_fun = F_ADD; d_b = sext_imm; d_mw = 1'b1; d_sign = 1'b1; end
         6'h04: begin d_fun = F_EQ; d_br = 1'b1; d_sign = 1'b1; end
         6'h05: begin d_fun = F_NE; d_br = 1'b1; d_sign = 1'b1; end
         6'h06: begin d_fun = F_LEZ; d_b = 32'h0; d_br = 1'b1; d_sign = 1'b1; end
         6'h07: begin d_fun = F_GTZ; d_b = 32'h0; d_br = 1'b1; d_sign = 1'b1; end
         6'h01: begin
            if (rt_idx == 5'd0) begin
               d_fun = F_LTZ; d_b = 32'h0; d_br = 1'b1; d_sign = 1'b1;
            end else begin
               d_ill = 1'b1;
            end
         end
         6'h02: begin end
         6'h03: begin d_a = pc_plus4; d_wr = RA_IDX; d_rw = 1'b1; end
         default: d_ill = 1'b1;
      endcase
      // $zero is never written
      if (d_wr == 5'd0) d_rw = 1'b0;
   end

   assign in_ready = ~out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         alu_a       <= 32'h0;
         alu_b       <= 32'h0;
         alu_fun     <= NOP_FUN;
         alu_sign    <= 1'b0;
         wr_addr     <= 5'd0;
         reg_write   <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         is_branch   <= 1'b0;
         is_jump_reg <= 1'b0;
         store_data  <= 32'h0;
         br_target   <= 32'h0;
         illegal     <= 1'b0;
      end else if (flush) begin
         // data fields may keep stale values; only the flags must die
         out_valid   <= 1'b0;
         reg_write   <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         is_branch   <= 1'b0;
         is_jump_reg <= 1'b0;
         illegal     <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid   <= 1'b1;
         alu_a       <= d_a;
         alu_b       <= d_b;
         alu_fun     <= d_fun;
         alu_sign    <= d_sign;
         wr_addr     <= d_wr;
         reg_write   <= d_rw;
         mem_read    <= d_mr;
         mem_write   <= d_mw;
         is_branch   <= d_br;
         is_jump_reg <= d_jr;
         store_data  <= rt_data;
         br_target   <= d_target;
         illegal     <= d_ill;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb/tb_id_ex_alu_issue.sv - randomized bench for id_ex_alu_issue against a table-driven model
module tb_id_ex_alu_issue;

   localparam logic [5:0] NOP = 6'b011010;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] instr, pc_plus4, rs_data, rt_data;
   logic [31:0] alu_a, alu_b, store_data, br_target;
   logic [5:0]  alu_fun;
   logic [4:0]  wr_addr;
   logic        alu_sign, reg_write, mem_read, mem_write, is_branch, is_jump_reg, illegal;

   always #5 clk = ~clk;

   id_ex_alu_issue dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc_plus4(pc_plus4), .rs_data(rs_data), .rt_data(rt_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
      .wr_addr(wr_addr), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .is_branch(is_branch), .is_jump_reg(is_jump_reg),
      .store_data(store_data), .br_target(br_target), .illegal(illegal)
   );

   typedef struct packed {
      logic [31:0] a, b;
      logic [5:0]  fun;
      logic        sign;
      logic [4:0]  wr;
      logic        rw, mr, mw, br, jr, ill;
      logic [31:0] sd, bt;
   } ent_t;

   // One row per legal encoding. asel: 0 rs, 1 shamt, 2 pc+4, 3 const 16.
   // bsel: 0 rt, 1 sext imm, 2 zext imm, 3 zero. wsel: 0 rd, 1 rt, 2 ra.
   // fl = {reg_write, mem_read, mem_write, is_branch, is_jump_reg}.
   typedef struct packed {
      logic [5:0] op, fn, fun;
      logic       sign;
      logic [1:0] asel, bsel, wsel;
      logic [4:0] fl;
   } row_t;

   row_t rows[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(input logic [5:0] op, input logic [5:0] fn, input logic [5:0] fun,
                               input logic sign, input logic [1:0] asel, input logic [1:0] bsel,
                               input logic [1:0] wsel, input logic [4:0] fl);
      row_t r;
      r.op = op; r.fn = fn; r.fun = fun; r.sign = sign;
      r.asel = asel; r.bsel = bsel; r.wsel = wsel; r.fl = fl;
      rows.push_back(r);
   endfunction

   function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] rs, input logic [31:0] rt);
      ent_t        e;
      logic [31:0] simm, zimm;
      logic [5:0]  op, fn;
      logic        found;
      simm = {{16{ins[15]}}, ins[15:0]};
      zimm = {16'h0000, ins[15:0]};
      op = ins[31:26];
      fn = ins[5:0];
      e = '0;
      e.a = rs; e.b = rt; e.fun = NOP; e.sd = rt;
      e.wr = (op == 6'h00) ? ins[15:11] : ins[20:16];
      e.bt = pc + simm * 32'd4;
      found = 1'b0;
      for (int i = 0; i < rows.size(); i++) begin
         if (!found && rows[i].op == op && (op != 6'h00 || rows[i].fn == fn)
             && (op != 6'h01 || ins[20:16] == 5'd0)) begin
            found = 1'b1;
            e.fun  = rows[i].fun;
            e.sign = rows[i].sign;
            case (rows[i].asel)
               2'd0: e.a = rs;
               2'd1: e.a = {27'h0, ins[10:6]};
               2'd2: e.a = pc;
               default: e.a = 32'd16;
            endcase
            case (rows[i].bsel)
               2'd0: e.b = rt;
               2'd1: e.b = simm;
               2'd2: e.b = zimm;
               default: e.b = 32'h0;
            endcase
            case (rows[i].wsel)
               2'd0: e.wr = ins[15:11];
               2'd1: e.wr = ins[20:16];
               default: e.wr = 5'd31;
            endcase
            {e.rw, e.mr, e.mw, e.br, e.jr} = rows[i].fl;
            if (e.wr == 5'd0) e.rw = 1'b0;
         end
      end
      e.ill = !found;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference state, advanced on each rising edge from the inputs seen there
   ent_t m;
   logic m_valid = 1'b0;
   logic m_init  = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_valid <= 1'b0;
         m       <= '{fun: NOP, default: '0};
         m_init  <= 1'b1;
      end else if (flush) begin
         m_valid <= 1'b0;
         m.rw <= 1'b0; m.mr <= 1'b0; m.mw <= 1'b0;
         m.br <= 1'b0; m.jr <= 1'b0; m.ill <= 1'b0;
      end else if (in_valid && (!m_valid || out_ready)) begin
         m_valid <= 1'b1;
         m       <= ref_decode(instr, pc_plus4, rs_data, rt_data);
      end else if (out_ready) begin
         m_valid <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("out_valid",   32'(out_valid),   32'(m_valid));
         chk("in_ready",    32'(in_ready),    32'(!m_valid || out_ready));
         chk("alu_a",       alu_a,            m.a);
         chk("alu_b",       alu_b,            m.b);
         chk("alu_fun",     32'(alu_fun),     32'(m.fun));
         chk("alu_sign",    32'(alu_sign),    32'(m.sign));
         chk("wr_addr",     32'(wr_addr),     32'(m.wr));
         chk("reg_write",   32'(reg_write),   32'(m.rw));
         chk("mem_read",    32'(mem_read),    32'(m.mr));
         chk("mem_write",   32'(mem_write),   32'(m.mw));
         chk("is_branch",   32'(is_branch),   32'(m.br));
         chk("is_jump_reg", 32'(is_jump_reg), 32'(m.jr));
         chk("store_data",  store_data,       m.sd);
         chk("br_target",   br_target,        m.bt);
         chk("illegal",     32'(illegal),     32'(m.ill));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] ins;
      row_t        r;
      ins = $urandom;
      if ($urandom_range(0, 6) != 0) begin
         r = rows[$urandom_range(0, rows.size() - 1)];
         ins[31:26] = r.op;
         if (r.op == 6'h00) ins[5:0] = r.fn;
         if (r.op == 6'h01) ins[20:16] = 5'd0;
      end
      if ($urandom_range(0, 9) == 0) ins[20:11] = 10'h0;
      return ins;
   endfunction

   initial begin
      add(6'h00,6'h20,6'b000000,1,0,0,0,5'b10000); add(6'h00,6'h21,6'b000000,0,0,0,0,5'b10000);
      add(6'h00,6'h22,6'b000001,1,0,0,0,5'b10000); add(6'h00,6'h23,6'b000001,0,0,0,0,5'b10000);
      add(6'h00,6'h24,6'b011000,0,0,0,0,5'b10000); add(6'h00,6'h25,6'b011110,0,0,0,0,5'b10000);
      add(6'h00,6'h26,6'b010110,0,0,0,0,5'b10000); add(6'h00,6'h27,6'b010001,0,0,0,0,5'b10000);
      add(6'h00,6'h2A,6'b110101,1,0,0,0,5'b10000); add(6'h00,6'h2B,6'b110101,0,0,0,0,5'b10000);
      add(6'h00,6'h00,6'b100000,0,1,0,0,5'b10000); add(6'h00,6'h02,6'b100001,0,1,0,0,5'b10000);
      add(6'h00,6'h03,6'b100011,0,1,0,0,5'b10000); add(6'h00,6'h04,6'b100000,0,0,0,0,5'b10000);
      add(6'h00,6'h06,6'b100001,0,0,0,0,5'b10000); add(6'h00,6'h07,6'b100011,0,0,0,0,5'b10000);
      add(6'h00,6'h08,NOP,      0,0,0,0,5'b00001); add(6'h00,6'h09,NOP,      0,2,0,0,5'b10001);
      add(6'h08,6'h00,6'b000000,1,0,1,1,5'b10000); add(6'h09,6'h00,6'b000000,0,0,1,1,5'b10000);
      add(6'h0A,6'h00,6'b110101,1,0,1,1,5'b10000); add(6'h0B,6'h00,6'b110101,0,0,1,1,5'b10000);
      add(6'h0C,6'h00,6'b011000,0,0,2,1,5'b10000); add(6'h0D,6'h00,6'b011110,0,0,2,1,5'b10000);
      add(6'h0E,6'h00,6'b010110,0,0,2,1,5'b10000); add(6'h0F,6'h00,6'b100000,0,3,2,1,5'b10000);
      add(6'h23,6'h00,6'b000000,1,0,1,1,5'b11000); add(6'h2B,6'h00,6'b000000,1,0,1,1,5'b00100);
      add(6'h04,6'h00,6'b110011,1,0,0,1,5'b00010); add(6'h05,6'h00,6'b110001,1,0,0,1,5'b00010);
      add(6'h06,6'h00,6'b111101,1,0,3,1,5'b00010); add(6'h07,6'h00,6'b111111,1,0,3,1,5'b00010);
      add(6'h01,6'h00,6'b111011,1,0,3,1,5'b00010);
      add(6'h02,6'h00,NOP,      0,0,0,1,5'b00000); add(6'h03,6'h00,NOP,      0,2,0,2,5'b10000);

      reset = 1'b1; in_valid = 1'b0; instr = '0; pc_plus4 = '0;
      rs_data = '0; rt_data = '0; flush = 1'b0; out_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      chk("lit_rst_valid", 32'(out_valid), 32'd0);
      chk("lit_rst_fun",   32'(alu_fun),   32'(6'b011010));
      chk("lit_rst_ready", 32'(in_ready),  32'd1);
      chk("lit_rst_a",     alu_a,          32'd0);

      instr = 32'h00221820; rs_data = 32'd5; rt_data = 32'd7; pc_plus4 = 32'h40;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      chk("lit_add_valid", 32'(out_valid), 32'd1);
      chk("lit_add_fun",   32'(alu_fun),   32'(6'b000000));
      chk("lit_add_sign",  32'(alu_sign),  32'd1);
      chk("lit_add_a",     alu_a,          32'd5);
      chk("lit_add_b",     alu_b,          32'd7);
      chk("lit_add_wr",    32'(wr_addr),   32'd3);
      chk("lit_add_rw",    32'(reg_write), 32'd1);

      instr = 32'h000520C3; rs_data = 32'd9; rt_data = 32'h80000000;
      step();
      chk("lit_sra_fun", 32'(alu_fun), 32'(6'b100011));
      chk("lit_sra_a",   alu_a,        32'd3);
      chk("lit_sra_b",   alu_b,        32'h80000000);
      chk("lit_sra_wr",  32'(wr_addr), 32'd4);

      out_ready = 1'b0; instr = 32'h00A43025; rs_data = 32'h0F0F0000; rt_data = 32'h000000F0;
      repeat (3) begin
         step();
         chk("lit_hold_ready", 32'(in_ready), 32'd0);
         chk("lit_hold_fun",   32'(alu_fun),  32'(6'b100011));
         chk("lit_hold_a",     alu_a,         32'd3);
      end
      out_ready = 1'b1;
      step();
      chk("lit_or_fun", 32'(alu_fun), 32'(6'b011110));
      chk("lit_or_wr",  32'(wr_addr), 32'd6);

      instr = 32'h1022FFFF; pc_plus4 = 32'h100;
      step();
      in_valid = 1'b0;
      chk("lit_beq_fun", 32'(alu_fun),   32'(6'b110011));
      chk("lit_beq_br",  32'(is_branch), 32'd1);
      chk("lit_beq_tgt", br_target,      32'h000000FC);
      chk("lit_beq_rw",  32'(reg_write), 32'd0);

      out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00221820;
      step();
      chk("lit_fl_held", 32'(out_valid), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("lit_fl_valid", 32'(out_valid), 32'd0);
      chk("lit_fl_br",    32'(is_branch), 32'd0);

      instr = 32'hFC000000; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lit_ill",    32'(illegal),   32'd1);
      chk("lit_ill_rw", 32'(reg_write), 32'd0);
      chk("lit_ill_v",  32'(out_valid), 32'd1);

      out_ready = 1'b0;
      step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("lit_mid_rst_valid", 32'(out_valid), 32'd0);
      chk("lit_mid_rst_fun",   32'(alu_fun),   32'(6'b011010));

      repeat (4000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         reset     = ($urandom_range(0, 299) == 0);
         instr     = gen_instr();
         pc_plus4  = {$urandom_range(0, 1) == 0 ? 2'b11 : 2'b00, 30'($urandom)} & 32'hFFFFFFFC;
         rs_data   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         rt_data   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
         step();
      end
      in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
